// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in, serial-out serializer.
// The PARITY state is only reachable when PISO_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int PISO_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_serializer.sv
// PISO serializer: valid/ready word load, MSB-first serial output with frame/done strobes.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             x_o,
  output logic             frame_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  piso_state_t      state_r, state_next_s;
  logic [WIDTH-1:0] shreg_r, shreg_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             accept_s;
  logic             x_next_s, frame_next_s, done_next_s, ready_next_s;
`ifdef PISO_PARITY_EN
  logic             parity_r, parity_next_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  assign accept_s = load_valid_i && load_ready_o;

  // Next-state, shifter and counter; outputs are then derived from these next values.
  always_comb begin
    state_next_s = state_r;
    shreg_next_s = shreg_r;
    cnt_next_s   = cnt_r;
`ifdef PISO_PARITY_EN
    parity_next_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = SHIFT;
          shreg_next_s = data_i;
          cnt_next_s   = '0;
`ifdef PISO_PARITY_EN
          parity_next_s = even_parity(data_i);
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_BIT) begin
`ifdef PISO_PARITY_EN
          state_next_s = PARITY;
          shreg_next_s = {shreg_r[WIDTH-2:0], 1'b0};
`else
          if (accept_s) begin
            state_next_s = SHIFT;
            shreg_next_s = data_i;
            cnt_next_s   = '0;
          end else begin
            state_next_s = IDLE;
            shreg_next_s = '0;
            cnt_next_s   = '0;
          end
`endif
        end else begin
          shreg_next_s = {shreg_r[WIDTH-2:0], 1'b0};
          cnt_next_s   = cnt_r + CNT_W'(1);
        end
      end
      PARITY: begin
`ifdef PISO_PARITY_EN
        if (accept_s) begin
          state_next_s  = SHIFT;
          shreg_next_s  = data_i;
          cnt_next_s    = '0;
          parity_next_s = even_parity(data_i);
        end else begin
          state_next_s = IDLE;
          shreg_next_s = '0;
          cnt_next_s   = '0;
        end
`else
        state_next_s = IDLE;
`endif
      end
      default: begin
        state_next_s = IDLE;
        shreg_next_s = '0;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output comes straight from a flop.
  always_comb begin
    x_next_s     = 1'b0;
    frame_next_s = 1'b0;
    done_next_s  = 1'b0;
    ready_next_s = 1'b0;
    case (state_next_s)
      IDLE: begin
        ready_next_s = 1'b1;
      end
      SHIFT: begin
        x_next_s     = shreg_next_s[WIDTH-1];
        frame_next_s = 1'b1;
`ifndef PISO_PARITY_EN
        done_next_s  = (cnt_next_s == LAST_BIT);
        ready_next_s = (cnt_next_s == LAST_BIT);
`endif
      end
      PARITY: begin
`ifdef PISO_PARITY_EN
        x_next_s     = parity_next_s;
        frame_next_s = 1'b1;
        done_next_s  = 1'b1;
        ready_next_s = 1'b1;
`else
        ready_next_s = 1'b1;
`endif
      end
      default: begin
        ready_next_s = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      cnt_r        <= '0;
      x_o          <= 1'b0;
      frame_o      <= 1'b0;
      done_o       <= 1'b0;
      load_ready_o <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else begin
      state_r      <= state_next_s;
      shreg_r      <= shreg_next_s;
      cnt_r        <= cnt_next_s;
      x_o          <= x_next_s;
      frame_o      <= frame_next_s;
      done_o       <= done_next_s;
      load_ready_o <= ready_next_s;
`ifdef PISO_PARITY_EN
      parity_r     <= parity_next_s;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer; a local shift variable stands in for the SIPO loopback.
// Expected frames grow by one parity bit when PISO_PARITY_EN is defined.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] data;
  logic         x;
  logic         frame;
  logic         done;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .data_i       (data),
    .x_o          (x),
    .frame_o      (frame),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #0.5;
    checks++; if (x !== 1'b0)          begin errors++; $display("FAIL reset_x: got %b want 0", x); end
    checks++; if (frame !== 1'b0)      begin errors++; $display("FAIL reset_frame: got %b want 0", frame); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", load_ready); end
    #0.5 reset = 1'b0;
  endtask

  task automatic test_single;
    logic [3:0] word;
    logic [3:0] sr;
    logic       exp_x, exp_last;
    word = 4'b1011;
    sr   = 4'b0000;
    load_valid = 1'b1; data = word;
    tick;
    load_valid = 1'b0; data = 4'b0000;
    for (int k = 0; k < FL; k++) begin
      exp_x    = (k < W) ? word[W-1-k] : ^word;
      exp_last = (k == FL - 1);
      checks++; if (x !== exp_x)           begin errors++; $display("FAIL single_x[%0d]: got %b want %b", k, x, exp_x); end
      checks++; if (frame !== 1'b1)        begin errors++; $display("FAIL single_frame[%0d]: got %b want 1", k, frame); end
      checks++; if (done !== exp_last)     begin errors++; $display("FAIL single_done[%0d]: got %b want %b", k, done, exp_last); end
      checks++; if (load_ready !== exp_last) begin errors++; $display("FAIL single_ready[%0d]: got %b want %b", k, load_ready, exp_last); end
      if (k < W) sr = {sr[2:0], x};
      tick;
    end
    checks++; if (frame !== 1'b0)      begin errors++; $display("FAIL single_end_frame: got %b want 0", frame); end
    checks++; if (x !== 1'b0)          begin errors++; $display("FAIL single_end_x: got %b want 0", x); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL single_end_done: got %b want 0", done); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL single_end_ready: got %b want 1", load_ready); end
    checks++; if (sr !== 4'b1011)      begin errors++; $display("FAIL single_loopback: got %b want 1011", sr); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] w;
    logic       exp_x, exp_last;
    int         f, b;
    load_valid = 1'b1; data = 4'b1011;
    tick;
    data = 4'b0110;
    for (int k = 0; k < 2 * FL; k++) begin
      if (k == FL) begin load_valid = 1'b0; data = 4'b0000; end
      f = k / FL;
      b = k % FL;
      w = (f == 0) ? 4'b1011 : 4'b0110;
      exp_x    = (b < W) ? w[W-1-b] : ^w;
      exp_last = (b == FL - 1);
      checks++; if (x !== exp_x)             begin errors++; $display("FAIL b2b_x[%0d]: got %b want %b", k, x, exp_x); end
      checks++; if (frame !== 1'b1)          begin errors++; $display("FAIL b2b_frame[%0d]: got %b want 1", k, frame); end
      checks++; if (load_ready !== exp_last) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, load_ready, exp_last); end
      tick;
    end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL b2b_end_frame: got %b want 0", frame); end
  endtask

  task automatic test_valid_while_busy;
    logic [3:0] w;
    logic       exp_x, exp_last;
    int         f, b;
    load_valid = 1'b1; data = 4'b1001;
    tick;
    load_valid = 1'b0; data = 4'b0000;
    for (int k = 0; k < 2 * FL; k++) begin
      if (k == 1)  begin load_valid = 1'b1; data = 4'b1111; end
      if (k == FL) begin load_valid = 1'b0; data = 4'b0000; end
      f = k / FL;
      b = k % FL;
      w = (f == 0) ? 4'b1001 : 4'b1111;
      exp_x    = (b < W) ? w[W-1-b] : ^w;
      exp_last = (b == FL - 1);
      checks++; if (x !== exp_x)             begin errors++; $display("FAIL busy_x[%0d]: got %b want %b", k, x, exp_x); end
      checks++; if (frame !== 1'b1)          begin errors++; $display("FAIL busy_frame[%0d]: got %b want 1", k, frame); end
      checks++; if (load_ready !== exp_last) begin errors++; $display("FAIL busy_ready[%0d]: got %b want %b", k, load_ready, exp_last); end
      tick;
    end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL busy_end_frame: got %b want 0", frame); end
  endtask

  task automatic test_reset_mid_frame;
    load_valid = 1'b1; data = 4'b1101;
    tick;
    load_valid = 1'b0; data = 4'b0000;
    tick;
    tick;
    checks++; if (x !== 1'b0 || frame !== 1'b1) begin errors++; $display("FAIL midrst_pre: got x=%b frame=%b want x=0 frame=1", x, frame); end
    #2 reset = 1'b1;
    #1;
    checks++; if (x !== 1'b0)          begin errors++; $display("FAIL midrst_x: got %b want 0", x); end
    checks++; if (frame !== 1'b0)      begin errors++; $display("FAIL midrst_frame: got %b want 0", frame); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", load_ready); end
    #1 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      checks++; if (frame !== 1'b0 || x !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet[%0d]: got frame=%b x=%b done=%b want 0 0 0", k, frame, x, done);
      end
    end
    load_valid = 1'b1; data = 4'b0110;
    tick;
    load_valid = 1'b0; data = 4'b0000;
    checks++; if (frame !== 1'b1 || x !== 1'b0) begin errors++; $display("FAIL midrst_new0: got frame=%b x=%b want 1 0", frame, x); end
    tick;
    checks++; if (x !== 1'b1) begin errors++; $display("FAIL midrst_new1: got %b want 1", x); end
    repeat (FL) tick;
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL midrst_new_end: got %b want 0", frame); end
  endtask

  initial begin
    reset = 1'b0;
    load_valid = 1'b0;
    data = 4'b0000;
    test_reset;
    tick;
    test_single;
    tick;
    test_back_to_back;
    tick;
    test_valid_while_busy;
    tick;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
